// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state, opcode and select encodings shared by the multi-cycle MIPS controller.
// Optional feature macro: MULTICYCLE_CTRL_ADDI_EN (addi support).
package multicycle_ctrl_pkg;
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] WB_MEM   = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] EXEC     = 4'd6;
  localparam logic [3:0] R_DONE   = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
  localparam logic [3:0] ADDI_EX  = 4'd10;
  localparam logic [3:0] ADDI_WB  = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MULTICYCLE_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J}) || (ADDI_EN && op == OP_ADDI);
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory bundle; master = controller, slave = datapath side.
// zero only qualifies pc_write_cond inside the datapath, so the controller modport does not read it.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
           illegal_op, state
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: combinational state -> control-vector lookup (ADDI states under MULTICYCLE_CTRL_ADDI_EN).
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl
);
  logic w_illegal;
  assign w_illegal = !op_legal(i_opcode);
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_4;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      DECODE: begin
        o_ctrl.alu_src_b  = SRCB_IMM_SL2;
        o_ctrl.alu_op     = ALUOP_ADD;
        o_ctrl.illegal_op = w_illegal;
        o_ctrl.instr_done = w_illegal;
      end
      MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      WB_MEM: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_DONE: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multi-cycle MIPS datapath with mem_ready-stalled memory states.
// Optional feature macro: MULTICYCLE_CTRL_ADDI_EN enables the addi states (ADDI_EX/ADDI_WB).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = FETCH
) (
  input logic clk,
  input logic rst_n,
  multicycle_ctrl_if.master bus
);
  logic [3:0] r_state;
  logic [3:0] w_next;
  ctrl_t      w_ctrl;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= RESET_STATE;
    else        r_state <= w_next;

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = bus.mem_ready ? DECODE : FETCH;
      DECODE:
        case (bus.opcode)
          OP_LW, OP_SW: w_next = MEM_ADDR;
          OP_RTYPE:     w_next = EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:      w_next = ADDI_EX;
`endif
          default:      w_next = FETCH;
        endcase
      MEM_ADDR: w_next = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   w_next = bus.mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:   w_next = bus.mem_ready ? FETCH : MEM_WR;
      EXEC:     w_next = R_DONE;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ADDI_EX:  w_next = ADDI_WB;
`endif
      default:  w_next = FETCH;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (bus.mem_ready),
    .i_opcode    (bus.opcode),
    .o_ctrl      (w_ctrl)
  );

  // FETCH strobes follow mem_ready, so hold them off while reset is asserted
  assign bus.pc_write      = w_ctrl.pc_write & rst_n;
  assign bus.ir_write      = w_ctrl.ir_write & rst_n;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond;
  assign bus.iord          = w_ctrl.iord;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.pc_source     = w_ctrl.pc_source;
  assign bus.instr_done    = w_ctrl.instr_done;
  assign bus.illegal_op    = w_ctrl.illegal_op;
  assign bus.state         = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle checks of state and the full control vector against hand-built constants.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // {pw,pwc,iord,mr,mw,irw}_{m2r,rd,rw,sa}_srcb_aluop_pcsrc_{done,ill}
  localparam logic [17:0] V_FETCH_R = 18'b100101_0000_01_00_00_00;
  localparam logic [17:0] V_FETCH_W = 18'b000100_0000_01_00_00_00;
  localparam logic [17:0] V_DEC     = 18'b000000_0000_11_00_00_00;
  localparam logic [17:0] V_DEC_ILL = 18'b000000_0000_11_00_00_11;
  localparam logic [17:0] V_MADDR   = 18'b000000_0001_10_00_00_00;
  localparam logic [17:0] V_MRD     = 18'b001100_0000_00_00_00_00;
  localparam logic [17:0] V_WBMEM   = 18'b000000_1010_00_00_00_10;
  localparam logic [17:0] V_MWR_W   = 18'b001010_0000_00_00_00_00;
  localparam logic [17:0] V_MWR_R   = 18'b001010_0000_00_00_00_10;
  localparam logic [17:0] V_EXEC    = 18'b000000_0001_00_10_00_00;
  localparam logic [17:0] V_RDONE   = 18'b000000_0110_00_00_00_10;
  localparam logic [17:0] V_BRANCH  = 18'b010000_0001_00_01_01_10;
  localparam logic [17:0] V_JUMP    = 18'b100000_0000_00_00_10_10;
  localparam logic [17:0] V_ADDI_EX = 18'b000000_0001_10_00_00_00;
  localparam logic [17:0] V_ADDI_WB = 18'b000000_0010_00_00_00_10;

  function automatic logic [17:0] outs();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic at(input string tag, input logic [3:0] st, input logic [17:0] v);
    #1;
    chk($sformatf("%s.state", tag), {28'd0, bus.state}, {28'd0, st});
    chk($sformatf("%s.ctrl", tag), {14'd0, outs()}, {14'd0, v});
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b0;
    bus.zero = 1'b0;
    #2;
    at("rst0", 4'd0, V_FETCH_W);
    at("rst1", 4'd0, V_FETCH_W);
    rst_n = 1'b1;
    bus.opcode = 6'b000000;
    at("r.f", 4'd0, V_FETCH_R);
    at("r.d", 4'd1, V_DEC);
    at("r.e", 4'd6, V_EXEC);
    at("r.w", 4'd7, V_RDONE);
    bus.opcode = 6'b100011;
    at("lw.f", 4'd0, V_FETCH_R);
    at("lw.d", 4'd1, V_DEC);
    at("lw.a", 4'd2, V_MADDR);
    bus.mem_ready = 1'b0;
    at("lw.rd0", 4'd3, V_MRD);
    at("lw.rd1", 4'd3, V_MRD);
    at("lw.rd2", 4'd3, V_MRD);
    bus.mem_ready = 1'b1;
    at("lw.rd3", 4'd3, V_MRD);
    at("lw.wb", 4'd4, V_WBMEM);
    bus.opcode = 6'b101011;
    bus.mem_ready = 1'b0;
    at("sw.fw", 4'd0, V_FETCH_W);
    bus.mem_ready = 1'b1;
    at("sw.f", 4'd0, V_FETCH_R);
    at("sw.d", 4'd1, V_DEC);
    at("sw.a", 4'd2, V_MADDR);
    bus.mem_ready = 1'b0;
    at("sw.w0", 4'd5, V_MWR_W);
    bus.mem_ready = 1'b1;
    at("sw.w1", 4'd5, V_MWR_R);
    bus.opcode = 6'b000100;
    bus.zero = 1'b1;
    at("beq1.f", 4'd0, V_FETCH_R);
    at("beq1.d", 4'd1, V_DEC);
    at("beq1.b", 4'd8, V_BRANCH);
    bus.zero = 1'b0;
    at("beq0.f", 4'd0, V_FETCH_R);
    at("beq0.d", 4'd1, V_DEC);
    at("beq0.b", 4'd8, V_BRANCH);
    bus.opcode = 6'b000010;
    at("j.f", 4'd0, V_FETCH_R);
    at("j.d", 4'd1, V_DEC);
    at("j.j", 4'd9, V_JUMP);
    bus.opcode = 6'b111111;
    at("ill.f", 4'd0, V_FETCH_R);
    at("ill.d", 4'd1, V_DEC_ILL);
    bus.opcode = 6'b001000;
    at("addi.f", 4'd0, V_FETCH_R);
`ifdef MULTICYCLE_CTRL_ADDI_EN
    at("addi.d", 4'd1, V_DEC);
    at("addi.e", 4'd10, V_ADDI_EX);
    at("addi.w", 4'd11, V_ADDI_WB);
`else
    at("addi.d", 4'd1, V_DEC_ILL);
`endif
    bus.opcode = 6'b000000;
    at("rr.f", 4'd0, V_FETCH_R);
    bus.mem_ready = 1'b0;
    at("rr.d", 4'd1, V_DEC);
    at("rr.e", 4'd6, V_EXEC);
    at("rr.w", 4'd7, V_RDONE);
    at("rr.fw", 4'd0, V_FETCH_W);
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b101011;
    at("swr.f", 4'd0, V_FETCH_R);
    at("swr.d", 4'd1, V_DEC);
    at("swr.a", 4'd2, V_MADDR);
    bus.mem_ready = 1'b0;
    at("swr.w", 4'd5, V_MWR_W);
    #1;
    chk("swr.pre", {28'd0, bus.state}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("swr.rst_mw", {31'd0, bus.mem_write}, 32'd0);
    at("swr.rst0", 4'd0, V_FETCH_W);
    bus.mem_ready = 1'b1;
    at("swr.rst1", 4'd0, V_FETCH_W);
    rst_n = 1'b1;
    bus.opcode = 6'b000000;
    at("post.f", 4'd0, V_FETCH_R);
    at("frc.d", 4'd1, V_DEC);
    at("frc.e", 4'd6, V_EXEC);
    #1;
    force dut.r_state = 4'd13;
    #1;
    chk("frc.state", {28'd0, bus.state}, 32'd13);
    chk("frc.ctrl", {14'd0, outs()}, 32'd0);
    release dut.r_state;
    @(posedge clk);
    #2;
    at("frc.f", 4'd0, V_FETCH_R);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and write-back and drives all datapath enables and mux selects. It also drives the 2-bit ALU operation code into the existing ALU control decoder: 00 = add, 01 = subtract, 10 = use the funct field. Memory accesses stall on a ready handshake, so one shared instruction/data memory can have variable latency.

## Interface
Parameters:
- RESET_STATE, default 4'd0 (FETCH): state entered on reset; must be a legal state encoding.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- opcode, input, 6: IR[31:26]; valid from DECODE onward.
- zero, input, 1: ALU zero flag; sampled in BRANCH.
- mem_ready, input, 1: memory has completed the current access this cycle.
- pc_write, output, 1: unconditional PC load.
- pc_write_cond, output, 1: PC load qualified by zero (beq).
- iord, output, 1: memory address mux; 0 = PC, 1 = ALUOut.
- mem_read, output, 1: memory read request.
- mem_write, output, 1: memory write request.
- ir_write, output, 1: instruction register load.
- mem_to_reg, output, 1: register write-back source; 1 = MDR.
- reg_dst, output, 1: register destination; 1 = rd, 0 = rt.
- reg_write, output, 1: register file write enable.
- alu_src_a, output, 1: ALU A source; 0 = PC, 1 = A register.
- alu_src_b, output, 2: ALU B source; 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- alu_op, output, 2: code into the ALU control decoder.
- pc_source, output, 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done, output, 1: one-cycle pulse on the final cycle of each instruction.
- illegal_op, output, 1: one-cycle pulse in DECODE when the opcode is unsupported.
- state, output, 4: current state, for debug.

## Operation
- Moore FSM. All outputs decode from the state register, except the handshake-gated strobes noted below. Any output not listed for a state is 0.
- Recognized opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000 (addi only when the configuration macro is defined).
- States and outputs:
  - FETCH (0): mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write = mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE (1): alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
    - lw or sw → MEM_ADDR
    - R-type → EXEC
    - beq → BRANCH
    - j → JUMP
    - addi → ADDI_EX
    - any other opcode → FETCH, with illegal_op=1 and instr_done=1.
  - MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD (3): mem_read=1, iord=1. Holds until mem_ready=1, then goes to WB_MEM.
  - WB_MEM (4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
  - MEM_WR (5): mem_write=1, iord=1. Holds until mem_ready=1; instr_done = mem_ready. Then goes to FETCH.
  - EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_DONE.
  - R_DONE (7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
  - JUMP (9): pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
  - ADDI_EX (10): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
  - ADDI_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- Encodings 12–15 are unreachable; if entered, go to FETCH on the next edge with all outputs 0.
- A request line (mem_read or mem_write) stays asserted and stable until mem_ready is seen. mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.

## Timing
- Reset: state=RESET_STATE (FETCH) asynchronously.
  - While rst_n=0, outputs equal the FETCH decode with pc_write=ir_write=0, instr_done=0 and illegal_op=0.
  - First fetch request appears in the first cycle after rst_n deasserts.
- Reset mid-instruction aborts immediately. No register or memory write may be asserted during reset.
- Latency, with mem_ready=1 on first request, in cycles: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2. Each memory wait cycle adds 1.
- instr_done is asserted exactly once per instruction. The next cycle is always FETCH.

## Configuration
- MULTICYCLE_CTRL_ADDI_EN defined: opcode 001000 dispatches to ADDI_EX/ADDI_WB.
- Undefined: states 10 and 11 are not built, and 001000 is treated as illegal (illegal_op pulse, return to FETCH).

## Structure
- Shared package holds:
  - state localparams (FETCH…ADDI_WB)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALU op codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - alu_src_b and pc_source select encodings.
- One optional sub-module, multicycle_ctrl_decode: purely combinational state→control-vector lookup. The state register and next-state logic stay in the top module.

## Test plan
- Reset with rst_n=0 mid-MEM_WR → mem_write=0 immediately, state=0; after release, FETCH with mem_read=1.
- R-type opcode, mem_ready=1 → states 0,1,6,7,0; alu_op=10 in EXEC; reg_write=1 and reg_dst=1 in cycle 4 only; one instr_done pulse.
- lw with mem_ready held low 3 cycles in MEM_RD → iord=1, mem_read=1 stable for 4 cycles; WB_MEM with mem_to_reg=1; total 8 cycles.
- beq with zero=1, then zero=0 → pc_write_cond=1, alu_op=01, pc_source=01 in state 8; each completes in 3 cycles.
- Opcode 111111 → illegal_op and instr_done pulse in DECODE, next state FETCH. With the macro undefined, 001000 behaves the same.
- Force state to 13 → next edge is FETCH, and no write strobe is asserted in the intervening cycle.
